// File: rtl/tdm_demux_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_pkg
//
// Shared definitions for the TDM demultiplexer slice:
//   - state_t       : framing FSM state encoding (ST_HUNT / ST_RUN)
//   - *_MIN / *_MAX : legal ranges for the CHANNELS and WIDTH parameters
//   - cnt_bits()    : width of a counter that must reach n-1 (never 0 bits)
//   - params_legal(): elaboration-time range check used by tdm_demux
//
// No ports; imported by tdm_demux and sipo_shift.
// ---------------------------------------------------------------------------
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CHANNELS_MIN = 2;
  localparam int CHANNELS_MAX = 16;
  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 16;

  // A counter covering 0..n-1 needs clog2(n) bits, but a degenerate n=1
  // would yield zero bits, so clamp to one.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_legal(input int channels, input int width);
    return (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX) &&
           (width    >= WIDTH_MIN)    && (width    <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/tdm_demux_sipo_shift.sv
// ---------------------------------------------------------------------------
// sipo_shift
//
// Serial-in / parallel-out shift register, MSB first: each enabled cycle the
// register moves up one place and takes d at its LSB.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears q
//   en     in   shift enable; q holds when low
//   clr    in   with en: discard the old contents and load d as the only bit
//   d      in   serial data bit
//   q      out  WIDTH-bit parallel contents
// ---------------------------------------------------------------------------
import tdm_demux_pkg::*;

module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;

  // A one-bit register has nothing to shift, so the slice expressions only
  // exist when there is more than one bit.
  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = d;
      assign fresh   = d;
    end else begin : g_multi
      assign shifted = {q[WIDTH-2:0], d};
      assign fresh   = {{(WIDTH-1){1'b0}}, d};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? fresh : shifted;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Time-division demultiplexer. A serial stream carries frames of CHANNELS
// slots, WIDTH bits each, MSB first. The block locks onto din_sync, rebuilds
// each slot word and writes it to that channel's registered output.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din         in   serial data bit
//   din_valid   in   qualifies din/din_sync; when low the block stalls
//   din_sync    in   first bit of a frame (slot 0 MSB)
//   ch_data     out  channel k word in [k*WIDTH +: WIDTH], holds last value
//   ch_valid    out  per-channel one-cycle update strobe
//   frame_done  out  one-cycle strobe alongside the last channel's strobe
//   locked      out  high while the framer is in RUN
//   sync_err    out  one-cycle strobe on a framing violation
// ---------------------------------------------------------------------------
import tdm_demux_pkg::*;

module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         din_sync,
  output logic [CHANNELS*WIDTH-1:0]    ch_data,
  output logic [CHANNELS-1:0]          ch_valid,
  output logic                         frame_done,
  output logic                         locked,
  output logic                         sync_err
);

  localparam int BW = cnt_bits(WIDTH);
  localparam int CW = cnt_bits(CHANNELS);

  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

  generate
    if (!params_legal(CHANNELS, WIDTH)) begin : g_bad_params
      $error("tdm_demux: CHANNELS and WIDTH must each lie in 2..16");
    end
  endgenerate

  state_t                      state_q;
  state_t                      state_d;
  logic [BW-1:0]               bit_cnt_q;
  logic [BW-1:0]               bit_cnt_d;
  logic [CW-1:0]               ch_cnt_q;
  logic [CW-1:0]               ch_cnt_d;
  logic [CHANNELS*WIDTH-1:0]   ch_data_d;
  logic [CHANNELS-1:0]         ch_valid_d;
  logic                        frame_done_d;
  logic                        sync_err_d;

  logic                        shift_en;
  logic                        shift_clr;
  logic [WIDTH-2:0]            shift_q;
  logic [WIDTH-1:0]            word;
  logic                        frame_start;

  // The shift register only needs to remember the WIDTH-1 bits that precede
  // the final one; the final bit is taken straight from din so the finished
  // word can be written on the same edge that accepts it.
  sipo_shift #(
    .WIDTH (WIDTH - 1)
  ) u_sipo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .clr   (shift_clr),
    .d     (din),
    .q     (shift_q)
  );

  assign word        = {shift_q, din};
  assign frame_start = (bit_cnt_q == '0) && (ch_cnt_q == '0);
  assign locked      = (state_q == ST_RUN);

  // Next-state, counter and output-register logic. A sync bit always starts
  // a fresh frame as slot 0 bit 1; in RUN it is only legal on the frame
  // boundary. A boundary bit without sync means lock was lost: the bit is
  // dropped and the framer goes back to hunting.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    ch_data_d    = ch_data;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    shift_en     = 1'b0;
    shift_clr    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (din_sync) begin
            state_d   = ST_RUN;
            shift_en  = 1'b1;
            shift_clr = 1'b1;
            bit_cnt_d = BIT_ONE;
            ch_cnt_d  = '0;
          end
        end

        ST_RUN: begin
          if (din_sync) begin
            sync_err_d = !frame_start;
            shift_en   = 1'b1;
            shift_clr  = 1'b1;
            bit_cnt_d  = BIT_ONE;
            ch_cnt_d   = '0;
          end else if (frame_start) begin
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              for (int k = 0; k < CHANNELS; k++) begin
                if (ch_cnt_q == CW'(k)) begin
                  ch_data_d[k*WIDTH +: WIDTH] = word;
                  ch_valid_d[k]               = 1'b1;
                end
              end
              bit_cnt_d = '0;
              if (ch_cnt_q == CH_LAST) begin
                ch_cnt_d     = '0;
                frame_done_d = 1'b1;
              end else begin
                ch_cnt_d = ch_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d   = ST_HUNT;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
        end
      endcase
    end
  end

  // State, counters and all outputs are registered; strobes fall back to 0
  // on any cycle that does not produce an event, including stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= '0;
      ch_cnt_q   <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      ch_data    <= ch_data_d;
      ch_valid   <= ch_valid_d;
      frame_done <= frame_done_d;
      sync_err   <= sync_err_d;
    end
  end

endmodule
